// File: rtl/seq_div_approx_rows_pkg.sv
// div_approx_pkg: shared state encoding, subtractor cells and width helpers for the sequential row divider.
//   exact_cell / approx_cell return {borrow_out, diff} for one bit position.
package div_approx_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic b);
        return {(~x & y) | (~(x ^ y) & b), x ^ y ^ b};
    endfunction

    // The borrow chain is cut: each approximate cell decides its borrow from x alone.
    function automatic logic [1:0] approx_cell(input logic x, input logic y);
        return {~x, x & ~y};
    endfunction

    function automatic int n_w(input int d_w);
        return 2 * d_w;
    endfunction

    function automatic int idx_w(input int d_w);
        return (d_w > 1) ? $clog2(d_w) : 1;
    endfunction

endpackage

// File: rtl/seq_div_approx_rows_row.sv
// div_row: one combinational restoring-division row built from exact or approximate subtractor cells.
//   t       : {partial remainder, next dividend bit}, D_W+1 bits
//   d       : divisor
//   use_approx : select the approximate cell for every bit of this row
//   q_bit   : quotient bit produced by this row
//   r_next  : partial remainder after the conditional restore
module div_row
    import div_approx_pkg::*;
#(
    parameter int D_W = 8
) (
    input  logic [D_W:0]   t,
    input  logic [D_W-1:0] d,
    input  logic           use_approx,
    output logic           q_bit,
    output logic [D_W-1:0] r_next
);

    logic [D_W:0]   b;
    logic [D_W-1:0] diff;

    assign b[0] = 1'b0;

    for (genvar g = 0; g < D_W; g++) begin : g_cell
        logic [1:0] ce;
        logic [1:0] ca;
        assign ce = exact_cell(t[g], d[g], b[g]);
        assign ca = approx_cell(t[g], d[g]);
        assign {b[g+1], diff[g]} = use_approx ? ca : ce;
    end

    // A set top bit of t means the subtraction cannot underflow regardless of the chain.
    assign q_bit  = t[D_W] | ~b[D_W];
    assign r_next = q_bit ? diff : t[D_W-1:0];

endmodule

// File: rtl/seq_div_approx_rows.sv
// seq_div_approx_rows: handshaked iterative divider, one restoring row per clock, optional approximate low rows.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : request handshake; in_n (2*D_W) / in_d (D_W) / in_approx sampled on accept
//   out_valid/out_ready : result handshake; out_q, out_r, out_ovf, out_dbz held while out_valid
module seq_div_approx_rows
    import div_approx_pkg::*;
#(
    parameter int D_W         = 8,
    parameter int APPROX_ROWS = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*D_W-1:0]   in_n,
    input  logic [D_W-1:0]     in_d,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_W-1:0]     out_q,
    output logic [D_W-1:0]     out_r,
    output logic               out_ovf,
    output logic               out_dbz
);

    localparam int N_W   = n_w(D_W);
    localparam int IDX_W = idx_w(D_W);
    localparam logic [IDX_W:0] AR = (IDX_W+1)'(APPROX_ROWS);

    state_t             state, state_nx;
    logic [D_W-1:0]     n_lo, d_q, r_q, q_sh, r_next;
    logic [IDX_W-1:0]   idx;
    logic               approx_q, fin, accept, row_approx, q_bit;

    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        accept     = in_valid & in_ready;
        row_approx = approx_q & ({1'b0, idx} < AR);
        state_nx   = (state == IDLE && in_valid)  ? BUSY :
                     (state == BUSY && fin)       ? DONE :
                     (state == DONE && out_ready) ? IDLE : state;
    end

    div_row #(.D_W(D_W)) u_row (
        .t          ({r_q, n_lo[idx]}),
        .d          (d_q),
        .use_approx (row_approx),
        .q_bit      (q_bit),
        .r_next     (r_next)
    );

    // The high dividend half seeds the remainder, so only the low half is kept for row bits.
    // fin marks that row 0 is done; the following edge publishes the result and enters DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            fin     <= 1'b0;
            out_q   <= '0;
            out_r   <= '0;
            out_ovf <= 1'b0;
            out_dbz <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                n_lo     <= in_n[D_W-1:0];
                d_q      <= in_d;
                approx_q <= in_approx;
                r_q      <= in_n[N_W-1:D_W];
                idx      <= IDX_W'(D_W-1);
                fin      <= 1'b0;
                out_ovf  <= in_n[N_W-1:D_W] >= in_d;
                out_dbz  <= in_d == '0;
            end else if (state == BUSY && !fin) begin
                r_q  <= r_next;
                q_sh <= {q_sh[D_W-2:0], q_bit};
                fin  <= idx == '0;
                idx  <= idx - 1'b1;
            end else if (state == BUSY) begin
                out_q <= q_sh;
                out_r <= r_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_div_approx_rows.sv
// tb_seq_div_approx_rows: scoreboard bench for seq_div_approx_rows with a bit-level row model.
module tb_seq_div_approx_rows;

    localparam int DW = 8;
    localparam int AR = 6;
    localparam int EW = 2*DW+2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*DW-1:0] in_n = '0;
    logic [DW-1:0]   in_d = '0;
    logic            in_approx = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_q, out_r;
    logic            out_ovf, out_dbz;

    int              n_chk = 0;
    int              n_pass = 0;
    logic [EW-1:0]   sb[$];
    logic [EW-1:0]   e;
    bit              stall = 1'b1;
    int              rdy_pct = 100;

    seq_div_approx_rows #(.D_W(DW), .APPROX_ROWS(AR)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_n(in_n), .in_d(in_d), .in_approx(in_approx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_ovf(out_ovf), .out_dbz(out_dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Exact rows use an arithmetic compare/subtract; approximate rows follow the cut-chain cell.
    function automatic logic [EW-1:0] model(input logic [2*DW-1:0] n, input logic [DW-1:0] d, input bit a);
        logic [DW-1:0] r, q;
        logic [DW:0]   t;
        logic          qi;
        r = n[2*DW-1:DW];
        q = '0;
        for (int i = DW-1; i >= 0; i--) begin
            t = {r, n[i]};
            if (a && i < AR) begin
                qi = t[DW] | t[DW-1];
                r  = qi ? (t[DW-1:0] & ~d) : t[DW-1:0];
            end else begin
                qi = t[DW] | (t[DW-1:0] >= d);
                r  = qi ? (t[DW-1:0] - d) : t[DW-1:0];
            end
            q[i] = qi;
        end
        return {n[2*DW-1:DW] >= d, d == '0, q, r};
    endfunction

    always @(negedge clk) begin
        out_ready = stall ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        if (rst_n && out_valid) begin
            chk("done_in_ready", 64'(in_ready), 64'(0));
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'(1), 64'(0));
            end else if (out_ready) begin
                e = sb.pop_front();
                chk("result", 64'({out_ovf, out_dbz, out_q, out_r}), 64'(e));
            end else begin
                chk("hold", 64'({out_ovf, out_dbz, out_q, out_r}), 64'(sb[0]));
            end
        end
    end

    task automatic send(input logic [2*DW-1:0] n, input logic [DW-1:0] d, input bit a, input logic [EW-1:0] exp);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 64'(0), 64'(1));
            return;
        end
        in_valid  = 1'b1;
        in_n      = n;
        in_d      = d;
        in_approx = a;
        @(posedge clk);
        sb.push_back(exp);
        #1;
        in_valid  = 1'b0;
        in_n      = 16'($urandom);
        in_d      = 8'($urandom);
        in_approx = 1'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int cnt;
        logic [2*DW-1:0] n;
        logic [DW-1:0]   d;
        bit              a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_outputs", 64'({out_ovf, out_dbz, out_q, out_r}), 64'(0));
        rst_n = 1'b1;

        send(16'd1000, 8'd7, 1'b0, {2'b00, 8'd142, 8'd6});
        @(posedge clk);
        #1;
        chk("busy_in_ready", 64'(in_ready), 64'(0));
        cnt = 1;
        while (!out_valid && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'(DW+1));

        repeat (20) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_n     = 16'($urandom);
            in_d     = 8'($urandom);
        end
        in_valid = 1'b0;
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_in_ready", 64'(in_ready), 64'(0));

        @(posedge clk);
        #2;
        stall     = 1'b0;
        in_valid  = 1'b1;
        in_n      = 16'd1000;
        in_d      = 8'd7;
        in_approx = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", 64'(out_valid), 64'(0));
        chk("release_in_ready", 64'(in_ready), 64'(1));
        sb.push_back({2'b00, 8'd128, 8'd104});
        @(posedge clk);
        #1;
        chk("accept_after_release", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        drain();

        send(16'h12AB, 8'd0, 1'b0, {2'b11, 8'hFF, 8'hAB});
        drain();
        send(16'hFF00, 8'h10, 1'b0, model(16'hFF00, 8'h10, 1'b0));
        drain();
        send(16'hFF00, 8'h10, 1'b1, model(16'hFF00, 8'h10, 1'b1));
        drain();

        send(16'hFF00, 8'd0, 1'b0, model(16'hFF00, 8'd0, 1'b0));
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_outputs", 64'({out_ovf, out_dbz, out_q, out_r}), 64'(0));
        rst_n = 1'b1;
        send(16'd1000, 8'd7, 1'b0, {2'b00, 8'd142, 8'd6});
        drain();

        rdy_pct = 60;
        for (int k = 0; k < 400; k++) begin
            d = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            n = 16'($urandom);
            if (d != 0 && $urandom_range(0, 1) == 1) n[2*DW-1:DW] = 8'($urandom % d);
            a = 1'($urandom);
            send(n, d, a, model(n, d, a));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
